// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   OVERSAMPLE     : baud ticks per serial bit (fixed at 16)
//   OS_W           : width of an oversample counter
//   DVSR_W_DEFAULT : default width of the baud divisor input
//   tx_state_t     : transmitter frame states
//   rx_state_t     : matching receiver frame states
//   even_parity    : even-parity helper (XOR of all bits)
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE        = 16;
   localparam int OS_W              = $clog2(OVERSAMPLE);
   localparam int DVSR_W_DEFAULT    = 11;
   localparam int DATA_BITS_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   // Even parity: the bit that makes the total count of ones even.
   // Callers zero-extend narrower payloads, which leaves the result unchanged.
   function automatic logic even_parity(input logic [15:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Baud-rate tick generator: counts 0..dvsr_i-1 while enabled and pulses
// tick_o for one clock on the last count, then wraps. Shared by TX and RX.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en_i     : counter runs only while high
//   clr_i    : synchronous clear to 0 (takes priority over en_i)
//   dvsr_i   : divisor, must be >= 1 (callers map 0 to 1)
//   tick_o   : one-clock pulse every dvsr_i enabled clocks
// ---------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DVSR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [DVSR_W-1:0] dvsr_i,
   output logic              tick_o
);

   logic [DVSR_W-1:0] cnt_q;
   logic [DVSR_W-1:0] cnt_d;
   logic              at_end_s;

   assign at_end_s = (cnt_q == (dvsr_i - DVSR_W'(1)));
   assign tick_o   = en_i && !clr_i && at_end_s;

   // Next count: clear wins, otherwise advance and wrap while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = {DVSR_W{1'b0}};
      end else if (en_i) begin
         if (at_end_s) begin
            cnt_d = {DVSR_W{1'b0}};
         end else begin
            cnt_d = cnt_q + DVSR_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Divisor counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= {DVSR_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
// UART transmitter: accepts one byte per valid/ready handshake and sends it
// LSB-first as an 8N1 frame. Each bit lasts OVERSAMPLE baud ticks, a tick
// every dvsr clocks (dvsr latched at accept, 0 treated as 1).
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (ports are unchanged).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   dvsr       : baud divisor
//   tx_data    : byte to send
//   tx_valid   : tx_data valid
//   tx_ready   : high only in IDLE; transfer when tx_valid && tx_ready
//   serial_out : registered serial line, idle high
//   tx_busy    : high from the cycle after accept until frame end
//   tx_done    : one-cycle pulse at frame end
// ---------------------------------------------------------------------------
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DVSR_W    = DVSR_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DVSR_W-1:0]    dvsr,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 serial_out,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

   tx_state_t            state_q,   state_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [OS_W-1:0]      os_q,      os_d;
   logic [DVSR_W-1:0]    dvsr_l_q,  dvsr_l_d;
   logic                 line_q,    line_d;
   logic                 ready_q,   ready_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q,  parity_d;
`endif

   logic accept_s;
   logic tick_s;
   logic bit_end_s;

   assign accept_s  = (state_q == IDLE) && tx_valid;
   // Last tick of the current bit period.
   assign bit_end_s = tick_s && (os_q == OS_LAST);

   // Tick generator is held in IDLE and cleared at accept so that bit
   // edges land exactly 16*dvsr clocks apart starting from the accept edge.
   uart_baud_tick #(
      .DVSR_W (DVSR_W)
   ) u_baud_tick (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q != IDLE),
      .clr_i  (accept_s),
      .dvsr_i (dvsr_l_q),
      .tick_o (tick_s)
   );

   // Frame sequencing: next state, shift register, counters and line level.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      dvsr_l_d  = dvsr_l_q;
      line_d    = line_q;
      done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      if (tick_s) begin
         os_d = os_q + OS_W'(1);
      end else begin
         os_d = os_q;
      end

      case (state_q)
         IDLE: begin
            line_d = 1'b1;
            if (accept_s) begin
               shift_d   = tx_data;
               dvsr_l_d  = (dvsr == {DVSR_W{1'b0}}) ? DVSR_W'(1) : dvsr;
               os_d      = {OS_W{1'b0}};
               bit_cnt_d = {BIT_W{1'b0}};
               line_d    = 1'b0;
               state_d   = START;
`ifdef UART_TX_PARITY_EN
               parity_d  = even_parity(16'(tx_data));
`endif
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               os_d    = {OS_W{1'b0}};
               line_d  = shift_q[0];
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               os_d = {OS_W{1'b0}};
               if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                  line_d  = parity_q;
                  state_d = PARITY;
`else
                  line_d  = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  // Next bit to send is shift_q[1]; present it as the
                  // register shifts so the line stays registered.
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  line_d    = shift_q[1];
               end
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               os_d    = {OS_W{1'b0}};
               line_d  = 1'b1;
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            line_d = 1'b1;
            if (bit_end_s) begin
               os_d    = {OS_W{1'b0}};
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            line_d  = 1'b1;
            state_d = IDLE;
         end
      endcase

      // Handshake flags follow the state being entered, so tx_done,
      // tx_ready and the fall of tx_busy share the same cycle.
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
   end

   // State and datapath registers; reset drives the line high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= {DATA_BITS{1'b0}};
         bit_cnt_q <= {BIT_W{1'b0}};
         os_q      <= {OS_W{1'b0}};
         dvsr_l_q  <= DVSR_W'(1);
         line_q    <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         os_q      <= os_d;
         dvsr_l_q  <= dvsr_l_d;
         line_q    <= line_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign serial_out = line_q;
   assign tx_ready   = ready_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
// Self-checking bench for uart_tx_serializer. Expected frames go into exp_q
// when a byte is accepted; a line decoder fills rx_q from serial_out and the
// test tasks pop and compare both queues. Per-cycle line levels and
// handshake flags are compared against a waveform built from the byte.
// Define UART_TX_PARITY_EN for both bench and RTL to check the parity build.
// ---------------------------------------------------------------------------
module tb_uart_tx_serializer;

   localparam int DVSR_W = 11;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS  = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int NBITS  = 10;
   localparam bit PAR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [DVSR_W-1:0] dvsr;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              serial_out;
   logic              tx_busy;
   logic              tx_done;

   int checks   = 0;
   int failures = 0;

   logic [9:0] exp_q[$];   // {frame_ok, parity, data}
   logic [9:0] rx_q[$];
   int         mon_period = 32;

   uart_tx_serializer #(
      .DATA_BITS (8),
      .DVSR_W    (DVSR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .dvsr       (dvsr),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .serial_out (serial_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // Expected line level for bit slot idx of a frame carrying d.
   function automatic logic exp_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PAR_EN && idx == 9) return ^d;
      return 1'b1;
   endfunction

   function automatic logic [9:0] exp_rec(input logic [7:0] d);
      return {1'b1, (PAR_EN ? ^d : 1'b0), d};
   endfunction

   // Line decoder: samples each bit in the middle of its period.
   initial begin : line_decoder
      int         cnt;
      int         b;
      logic [7:0] d;
      logic       p;
      logic       ok;
      logic       active;
      active = 1'b0; cnt = 0; b = 0; d = 8'h00; p = 1'b0; ok = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
         end else if (!active) begin
            if (serial_out == 1'b0) begin
               active = 1'b1; cnt = 0; b = 0; d = 8'h00; p = 1'b0; ok = 1'b1;
            end
         end else begin
            cnt++;
            if (cnt == b * mon_period + mon_period / 2) begin
               if (b == NBITS - 1)  ok = ok & (serial_out == 1'b1);
               else if (b == 0)     ok = ok & (serial_out == 1'b0);
               else if (b <= 8)     d[b-1] = serial_out;
               else                 p = serial_out;
               if (b == NBITS - 1) begin
                  rx_q.push_back({ok, p, d});
                  active = 1'b0;
               end
               b++;
            end
         end
      end
   end

   // Sends one byte and traces line and handshake for the whole frame.
   // k counts negedges after the accept edge; tx_done is due at k == L.
   task automatic send_and_trace(input logic [7:0] d, input int dv_l,
                                 output int wave_err, output int done_k,
                                 output int hs_err);
      int   L;
      int   w;
      logic exp_line;
      L = NBITS * 16 * dv_l;
      wave_err = 0; done_k = -1; hs_err = 0;
      @(posedge clk); #1;
      tx_data = d; tx_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!tx_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!tx_ready) hs_err++;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      exp_q.push_back(exp_rec(d));
      dvsr = dvsr + 11'd3;             // must not affect the frame in flight
      for (int k = 0; k <= L + 1; k++) begin
         @(negedge clk);
         exp_line = (k < L) ? exp_bit(d, k / (16 * dv_l)) : 1'b1;
         if (serial_out !== exp_line) wave_err++;
         if (tx_done === 1'b1 && done_k < 0) done_k = k;
         if (tx_done  !== (k == L)) hs_err++;
         if (tx_busy  !== (k <  L)) hs_err++;
         if (tx_ready !== (k >= L)) hs_err++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; dvsr = 11'd2;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL reset_serial_out: got %b expected 1", serial_out); end
      checks++; if (tx_ready !== 1'b1)   begin failures++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
      checks++; if (tx_busy !== 1'b0)    begin failures++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
      checks++; if (tx_done !== 1'b0)    begin failures++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_scoreboard(input string name, input int n);
      logic [9:0] e;
      logic [9:0] r;
      checks++;
      if (rx_q.size() != n || exp_q.size() != n) begin
         failures++;
         $display("FAIL %s_count: got rx=%0d exp=%0d expected %0d", name, rx_q.size(), exp_q.size(), n);
      end
      while (rx_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         r = rx_q.pop_front();
         checks++;
         if (r !== e) begin
            failures++;
            $display("FAIL %s_frame: got %h expected %h", name, r, e);
         end
      end
      exp_q.delete();
      rx_q.delete();
   endtask

   task automatic test_frame_a5;
      int we, dk, he;
      dvsr = 11'd2; mon_period = 32;
      send_and_trace(8'hA5, 2, we, dk, he);
      checks++; if (we != 0) begin failures++; $display("FAIL a5_wave: got %0d bad cycles expected 0", we); end
      checks++; if (dk + 1 != 1 + NBITS * 16 * 2) begin failures++; $display("FAIL a5_latency: got %0d expected %0d", dk + 1, 1 + NBITS * 32); end
      checks++; if (he != 0) begin failures++; $display("FAIL a5_handshake: got %0d errors expected 0", he); end
      check_scoreboard("a5", 1);
   endtask

   task automatic test_dvsr_zero;
      int we, dk, he;
      dvsr = 11'd0; mon_period = 16;
      send_and_trace(8'h55, 1, we, dk, he);
      checks++; if (we != 0) begin failures++; $display("FAIL dvsr0_wave: got %0d bad cycles expected 0", we); end
      checks++; if (dk + 1 != 1 + NBITS * 16) begin failures++; $display("FAIL dvsr0_latency: got %0d expected %0d", dk + 1, 1 + NBITS * 16); end
      checks++; if (he != 0) begin failures++; $display("FAIL dvsr0_handshake: got %0d errors expected 0", he); end
      check_scoreboard("dvsr0", 1);
   endtask

   task automatic test_back_to_back;
      int   L;
      int   we;
      int   de;
      int   last_done;
      int   w;
      logic exp_line;
      L = NBITS * 32;
      we = 0; de = 0; last_done = -1;
      dvsr = 11'd2; mon_period = 32;
      @(posedge clk); #1;
      tx_data = 8'h00; tx_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!tx_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk); #1;
      tx_data = 8'hFF;                 // offered while busy: must wait
      exp_q.push_back(exp_rec(8'h00));
      exp_q.push_back(exp_rec(8'hFF));
      for (int k = 0; k <= 2 * L + 1; k++) begin
         @(negedge clk);
         if (k < L)           exp_line = exp_bit(8'h00, k / 32);
         else if (k == L)     exp_line = 1'b1;
         else if (k <= 2 * L) exp_line = exp_bit(8'hFF, (k - L - 1) / 32);
         else                 exp_line = 1'b1;
         if (serial_out !== exp_line) we++;
         if (tx_done !== (k == L || k == 2 * L + 1)) de++;
         if (tx_done === 1'b1) last_done = k;
         if (k == L + 1) tx_valid = 1'b0;
      end
      checks++; if (w >= 200) begin failures++; $display("FAIL b2b_accept_timeout: got %0d cycles expected <200", w); end
      checks++; if (we != 0) begin failures++; $display("FAIL b2b_wave: got %0d bad cycles expected 0", we); end
      checks++; if (de != 0) begin failures++; $display("FAIL b2b_done: got %0d errors expected 0", de); end
      checks++; if (last_done + 1 != 2 * (1 + L)) begin failures++; $display("FAIL b2b_total: got %0d expected %0d", last_done + 1, 2 * (1 + L)); end
      check_scoreboard("b2b", 2);
   endtask

   task automatic test_reset_mid;
      int w;
      int we, dk, he;
      dvsr = 11'd2; mon_period = 32;
      @(posedge clk); #1;
      tx_data = 8'hA5; tx_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!tx_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (4 * 32 + 11) @(negedge clk);   // middle of data bit 3 (a 0)
      checks++; if (serial_out !== 1'b0) begin failures++; $display("FAIL mid_bit3: got %b expected 0", serial_out); end
      rst = 1'b1;
      #1;
      checks++; if (serial_out !== 1'b1) begin failures++; $display("FAIL mid_rst_line: got %b expected 1", serial_out); end
      checks++; if (tx_ready !== 1'b1)   begin failures++; $display("FAIL mid_rst_ready: got %b expected 1", tx_ready); end
      checks++; if (tx_busy !== 1'b0)    begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", tx_busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      rx_q.delete();
      dvsr = 11'd2;
      send_and_trace(8'h12, 2, we, dk, he);
      checks++; if (we != 0) begin failures++; $display("FAIL post_rst_wave: got %0d bad cycles expected 0", we); end
      checks++; if (dk != NBITS * 32) begin failures++; $display("FAIL post_rst_done: got %0d expected %0d", dk, NBITS * 32); end
      checks++; if (he != 0) begin failures++; $display("FAIL post_rst_handshake: got %0d errors expected 0", he); end
      check_scoreboard("post_rst", 1);
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      int         we, dk, he;
      logic [9:0] r;
      dvsr = 11'd1; mon_period = 16;
      send_and_trace(8'hA5, 1, we, dk, he);
      checks++; if (we != 0) begin failures++; $display("FAIL par_a5_wave: got %0d bad cycles expected 0", we); end
      checks++; if (dk + 1 != 177) begin failures++; $display("FAIL par_a5_latency: got %0d expected 177", dk + 1); end
      checks++;
      if (rx_q.size() != 1) begin
         failures++; $display("FAIL par_a5_count: got %0d expected 1", rx_q.size());
      end else begin
         r = rx_q[0];
         if (r[8] !== 1'b0) begin failures++; $display("FAIL par_a5_bit: got %b expected 0", r[8]); end
      end
      check_scoreboard("par_a5", 1);
      send_and_trace(8'h07, 1, we, dk, he);
      checks++; if (we != 0) begin failures++; $display("FAIL par_07_wave: got %0d bad cycles expected 0", we); end
      checks++; if (he != 0) begin failures++; $display("FAIL par_07_handshake: got %0d errors expected 0", he); end
      checks++;
      if (rx_q.size() != 1) begin
         failures++; $display("FAIL par_07_count: got %0d expected 1", rx_q.size());
      end else begin
         r = rx_q[0];
         if (r[8] !== 1'b1) begin failures++; $display("FAIL par_07_bit: got %b expected 1", r[8]); end
      end
      check_scoreboard("par_07", 1);
   endtask
`endif

   initial begin
      test_reset();
      test_frame_a5();
      test_dvsr_zero();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit stage directly upstream of uart_system_top; drives the serial line that feeds its serial_in.
- Accepts one byte per valid/ready handshake and serializes it LSB-first: 8N1 frame, optional even parity.
- Generates its own 16x oversampling tick from the same dvsr divisor the receiver uses, so one bit lasts 16*dvsr clocks.
- Serves both as a loopback source for receiver verification and as the TX half of the UART.

Parameters:
DATA_BITS, 8, payload bits per frame
DVSR_W, 11, width of dvsr input
OVERSAMPLE, 16, ticks per bit (fixed; sourced from package)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
dvsr  input  DVSR_W  baud divisor; tick every dvsr clocks; 0 treated as 1
tx_data  input  DATA_BITS  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  high in IDLE only; transfer on tx_valid && tx_ready
serial_out  output  1  serial line, idle high
tx_busy  output  1  high from accept cycle+1 until frame end
tx_done  output  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, immediate): state IDLE; serial_out=1, tx_ready=1, tx_busy=0, tx_done=0; tick counter, bit counter and shift register cleared.
- Reset mid-frame: line returns high at once; the partial frame is abandoned.
- Accept cycle:
  - tx_data latched into the shift register.
  - dvsr latched, with 0 mapped to 1. dvsr changes mid-frame have no effect.
  - Tick counter and oversample counter cleared.
- Cycle after accept: serial_out=0 (start bit), tx_ready=0, tx_busy=1.
- Tick generator:
  - Counter runs 0..dvsr_l-1, pulses tick at dvsr_l-1, then wraps.
  - Runs only outside IDLE, so bit edges align exactly to accept.
- State machine (each non-IDLE state lasts exactly 16 ticks = 16*dvsr_l clocks):
  - IDLE -> START on accept.
  - START -> DATA after 16 ticks; serial_out = shift[0].
  - DATA: after each 16 ticks, shift right and increment bit count. After bit DATA_BITS-1 -> STOP (or PARITY if enabled).
  - STOP: serial_out=1. After 16 ticks -> IDLE; tx_done=1 for that one cycle; tx_ready=1 and tx_busy=0 from the same cycle.
- Latency: accept to tx_done = 1 + 10*16*dvsr_l clocks without parity.
- Back-to-back: tx_valid held high means the next byte is accepted in the tx_done cycle and its start bit follows immediately. No idle gap beyond the single accept cycle.
- tx_valid while busy: ignored; the data is not consumed and no error is raised.
- serial_out is registered (glitch-free).

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state between DATA and STOP, 16 ticks long. serial_out = XOR of the 8 data bits (even parity). Frame = 11 bits; latency 1 + 11*16*dvsr_l.
- Undefined: no PARITY state; 10-bit 8N1 frame. Ports are identical in both builds.

Decomposition:
- Shared package uart_pkg holds:
  - localparam OVERSAMPLE=16
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - default DVSR_W
  - the receiver's matching rx state enum
- One sub-module, uart_baud_tick: divisor counter with enable, clear, dvsr input and tick output. It is reusable by the receiver.

Test Plan:
- dvsr=2, send 0xA5 -> serial_out low 32 clocks, then bits 1,0,1,0,0,1,0,1 at 32 clocks each, then high 32 clocks; tx_done pulses exactly 321 clocks after the accept edge.
- Loopback into uart_system_top, dvsr=2, send 0xA5 then 0x3C -> byte_ready asserts twice; data_out=0xA5, then 0x3C.
- tx_valid held high with 0x00 then 0xFF -> second start bit begins the cycle after the first tx_done; total 2*(1+320) clocks; no extra idle bits on the line.
- dvsr=0 -> bit period 16 clocks; frame of 0x55 completes in 161 clocks.
- Reset asserted during data bit 3 of 0xA5 -> serial_out=1 in the same cycle, tx_ready=1; next send of 0x12 is a clean, correct frame.
- UART_TX_PARITY_EN, dvsr=1 -> 0xA5 gives parity bit 0, 0x07 gives parity bit 1, each 16 clocks wide before the stop bit; tx_done at 177 clocks.
